// File: rtl/div_unit_if.sv
// Purpose : EX-stage <-> divider handshake bundle (request operands, result, status).
// Latency : n/a (wires only).
// Backpr. : requester holds start until ready; stall is start & ~ready.
// Signals : start/div_signed/opdata1/opdata2/annul from EX; result/ready/busy from divider.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                start;
  logic                div_signed;
  logic [DATA_W-1:0]   opdata1;
  logic [DATA_W-1:0]   opdata2;
  logic                annul;
  logic [2*DATA_W-1:0] result;
  logic                ready;
  logic                busy;

  // EX side: issues the request and consumes the result.
  modport master (
    output start, div_signed, opdata1, opdata2, annul,
    input  result, ready, busy
  );

  // Divider side.
  modport slave (
    input  start, div_signed, opdata1, opdata2, annul,
    output result, ready, busy
  );
endinterface

// File: rtl/div_unit.sv
// Purpose : radix-2 restoring divider for DIV/DIVU; result = {remainder (HI), quotient (LO)}.
// Latency : ready after sampling edge + DATA_W (nonzero divisor) or + 1 (zero divisor).
// Backpr. : EX holds start until ready; END is held while start stays high, annul flushes.
// Ports   : clk, rst (sync, active-high); s_div = div_unit_if.slave handshake bundle.
module div_unit #(
  parameter int DATA_W = 32
) (
  input logic      clk,
  input logic      rst,
  div_unit_if.slave s_div
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [2*DATA_W-1:0] r_result;

  logic                w_go;
  logic                w_last;
  logic                w_neg1;
  logic                w_neg2;
  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_trial;
  logic [DATA_W-1:0]   w_rem_nxt;
  logic [DATA_W-1:0]   w_quo_nxt;
  logic [DATA_W-1:0]   w_rem_fix;
  logic [DATA_W-1:0]   w_quo_fix;

  assign w_go   = s_div.start & ~s_div.annul;
  assign w_last = (r_state == S_ON) && (r_cnt == CNT_W'(DATA_W - 1));

  // Magnitudes of the operands; only DIV treats the MSB as a sign.
  assign w_neg1 = s_div.div_signed & s_div.opdata1[DATA_W-1];
  assign w_neg2 = s_div.div_signed & s_div.opdata2[DATA_W-1];
  assign w_abs1 = w_neg1 ? (~s_div.opdata1 + 1'b1) : s_div.opdata1;
  assign w_abs2 = w_neg2 ? (~s_div.opdata2 + 1'b1) : s_div.opdata2;

  // One restoring step: the quotient register starts out holding the dividend,
  // so its MSB shifts into the partial remainder while quotient bits enter at the LSB.
  // The partial remainder is always below the divisor, so DATA_W+1 bits suffice.
  assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_divisor};
  assign w_rem_nxt = w_trial[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_quo_nxt = {r_quo[DATA_W-2:0], ~w_trial[DATA_W]};

  // Sign correction: quotient negative when signs differ, remainder follows the dividend.
  // 0x80000000 / -1 comes out as 0x80000000 with no special handling.
  assign w_quo_fix = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_rem_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt = (s_div.opdata2 == '0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        w_state_nxt = s_div.annul ? S_IDLE : S_END;
      end
      S_ON: begin
        if (s_div.annul) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        // Hold the result while EX keeps start up; one start hold = one operation.
        w_state_nxt = w_go ? S_END : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_neg_q   <= w_neg1 ^ w_neg2;
            r_neg_r   <= w_neg1;
            r_quo     <= w_abs1;
            r_divisor <= w_abs2;
            r_cnt     <= '0;
            // On divide-by-zero the raw dividend is parked in r_rem for the HI half.
            r_rem     <= (s_div.opdata2 == '0) ? s_div.opdata1 : '0;
          end
        end
        S_DIVZERO: begin
          if (!s_div.annul) begin
            r_result <= {r_rem, {DATA_W{1'b1}}};
          end
        end
        S_ON: begin
          if (!s_div.annul) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (w_last) begin
              r_result <= {w_rem_fix, w_quo_fix};
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign s_div.result = r_result;
  assign s_div.ready  = (r_state == S_END);
  assign s_div.busy   = (r_state != S_IDLE);

endmodule
